// File: rtl/morse_tx.sv
// Morse character transmitter: sends one character of 1..5 dot/dash elements
// on KEY with standard Morse timing (dot = 1 unit, dash = 3 units,
// inter-element gap = 1 unit, trailing character gap = 3 units).
//
// Ports:
//   CLK      - clock, all state changes on the rising edge
//   RESET    - synchronous active-high reset
//   START    - request to send one character (sampled every cycle)
//   LEN      - element count of the character, legal 1..5
//   PATTERN  - bit k = element k (0 = dot, 1 = dash), element 0 sent first
//   READY    - idle, START can be accepted
//   BUSY     - character in progress (inverse of READY)
//   KEY      - registered keying output, 1 = tone on
//   DONE     - one-cycle pulse in the first idle cycle after a character
module morse_tx #(
    parameter int unsigned UNIT_CYCLES = 25000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [2:0] LEN,
    input  logic [4:0] PATTERN,
    output logic       READY,
    output logic       BUSY,
    output logic       KEY,
    output logic       DONE
);

    // 27 bits hold 3 * (2^25 - 1) without overflow.
    localparam int unsigned CNT_W = 27;
    localparam logic [CNT_W-1:0] DOT_LOAD  = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DASH_LOAD = CNT_W'(3 * UNIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        CGAP  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [2:0]       len_q, len_d;
    logic [4:0]       pat_q, pat_d;
    logic             key_q, key_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;

    logic             start_ok;
    logic [2:0]       idx_nxt;
    logic             more_elems;

    assign start_ok   = START && (LEN != 3'd0) && (LEN <= 3'd5);
    assign idx_nxt    = idx_q + 3'd1;
    assign more_elems = ({1'b0, idx_q} + 4'd1) < {1'b0, len_q};

    // Next-state, counter and output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        len_d   = len_q;
        pat_d   = pat_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    len_d   = LEN;
                    pat_d   = PATTERN;
                    idx_d   = 3'd0;
                    state_d = MARK;
                    cnt_d   = PATTERN[0] ? DASH_LOAD : DOT_LOAD;
                end
            end
            MARK: begin
                if (cnt_q == '0) begin
                    if (more_elems) begin
                        state_d = SPACE;
                        cnt_d   = DOT_LOAD;
                    end else begin
                        state_d = CGAP;
                        cnt_d   = DASH_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SPACE: begin
                if (cnt_q == '0) begin
                    idx_d   = idx_nxt;
                    state_d = MARK;
                    cnt_d   = pat_q[idx_nxt] ? DASH_LOAD : DOT_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CGAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs follow the next state so they are valid as flops.
        key_d   = (state_d == MARK);
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            len_q   <= 3'd0;
            pat_q   <= 5'd0;
            key_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            pat_q   <= pat_d;
            key_q   <= key_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign KEY   = key_q;
    assign DONE  = done_q;
    assign READY = ready_q;
    assign BUSY  = busy_q;

endmodule
